pipe_hazard_ctrl: RTL

Central hazard/sequencing controller for the 5-stage RV32I pipeline. It watches the ID and EX stages, detects load-use hazards, taken-branch/jump redirects and data-memory back-pressure, and drives the per-stage clock-enable, stall and flush signals (IF/ID/EX) that the decode stage and its neighbours consume. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: load-use stalls,
// branch redirect flushes, memory freeze, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_id_valid,
    input  logic [4:0]        i_id_rs1_addr,
    input  logic [4:0]        i_id_rs2_addr,
    input  logic              i_ex_valid,
    input  logic              i_ex_is_load,
    input  logic [4:0]        i_ex_rd_addr,
    input  logic              i_branch_taken,
    input  logic              i_mem_busy,
    output logic              o_if_ce,
    output logic              o_id_ce,
    output logic              o_ex_ce,
    output logic              o_if_stall,
    output logic              o_id_stall,
    output logic              o_id_flush,
    output logic              o_ex_flush,
    output logic              o_pc_sel,
    output logic [1:0]        o_state,
    output logic [PERF_W-1:0] o_stall_cnt
);

    // state       | meaning
    // RUN         | normal issue, watching for load-use and redirects
    // LOAD_STALL  | one bubble cycle after a load-use stall
    // FLUSH       | extra wrong-path cycles after a redirect
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_UNUSED     = 2'd3
    } state_e;

    localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [PERF_W-1:0] perf_q, perf_d;
    logic              perf_inc;
    logic              load_use, redirect;

    assign load_use = i_ex_valid & i_ex_is_load & (i_ex_rd_addr != 5'd0) & i_id_valid &
                      ((i_ex_rd_addr == i_id_rs1_addr) | (i_ex_rd_addr == i_id_rs2_addr));
    assign redirect = i_id_valid & i_branch_taken;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        perf_inc   = 1'b0;
        o_if_ce    = 1'b1;
        o_id_ce    = 1'b1;
        o_ex_ce    = 1'b1;
        o_if_stall = 1'b0;
        o_id_stall = 1'b0;
        o_id_flush = 1'b0;
        o_ex_flush = 1'b0;
        o_pc_sel   = 1'b0;

        if (i_mem_busy) begin
            o_if_ce  = 1'b0;
            o_id_ce  = 1'b0;
            o_ex_ce  = 1'b0;
            perf_inc = 1'b1;
        end else begin
            case (state_q)
                ST_RUN, ST_LOAD_STALL: begin
                    // EX holds a bubble in LOAD_STALL, so only RUN can see load-use
                    if (state_q == ST_RUN && load_use) begin
                        o_if_stall = 1'b1;
                        o_id_stall = 1'b1;
                        o_ex_flush = 1'b1;
                        perf_inc   = 1'b1;
                        state_d    = ST_LOAD_STALL;
                    end else if (redirect) begin
                        o_pc_sel   = 1'b1;
                        o_id_flush = 1'b1;
                        if (MULTI_FLUSH) begin
                            cnt_d   = FLUSH_LOAD;
                            state_d = ST_FLUSH;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    o_id_flush = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = 3'd0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end

        if (!rst_n) begin
            o_if_ce    = 1'b0;
            o_id_ce    = 1'b0;
            o_ex_ce    = 1'b0;
            o_if_stall = 1'b0;
            o_id_stall = 1'b0;
            o_id_flush = 1'b1;
            o_ex_flush = 1'b1;
            o_pc_sel   = 1'b0;
        end
    end

    assign perf_d = (perf_inc && !(&perf_q)) ? perf_q + 1'b1 : perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            perf_q  <= perf_d;
        end
    end

    assign o_state     = state_q;
    assign o_stall_cnt = perf_q;

endmodule
